// File: rtl/rv_pkg.sv
// Shared RV64I fetch definitions: widths, alignment, fetch-queue entry and PC helpers.
package rv_pkg;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned ILEN        = 32;
    localparam int unsigned INSTR_ALIGN = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    // One buffered fetch result, as handed to decode.
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    // Force a PC onto the instruction grid; low bits are ignored, not trapped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

    // Sequential successor; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_ALIGN);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetch entries with push, pop and synchronous flush.
// Overflow is prevented upstream by the request credit limit.
module fetch_queue
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          pop_ok;

    assign empty  = (count_q == '0);
    assign pop_ok = pop && !empty;
    assign head   = mem_q[rd_ptr_q];
    assign count  = count_q;

    // Pointer and occupancy state; power-of-2 depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop_ok);
        end
    end

    // Entry storage; contents are only meaningful where count says so, so no reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV64I instruction-fetch stage: in-order credit-limited requests to instruction memory,
// response buffering in fetch_queue, and redirect flush with stale-response dropping.
module fetch_stage
    import rv_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
);

    localparam int unsigned CW         = $clog2(DEPTH + 1);
    localparam int unsigned CW1        = CW + 1;
    localparam logic [CW:0] CREDIT_MAX = CW1'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic            run_q;

    logic            req_fire;
    logic            rsp_fire;
    logic [CW:0]     credit_used;

    logic            q_push;
    logic            q_flush;
    logic            q_empty;
    logic [CW-1:0]   q_count;
    fetch_entry_t    q_head;
    fetch_entry_t    q_push_data;

    // Credits cover both in-flight requests and buffered entries, so a response always fits.
    assign credit_used    = {1'b0, inflight_q} + {1'b0, q_count};
    assign imem_req_valid = run_q && !redirect_valid && (credit_used < CREDIT_MAX);
    assign imem_req_addr  = fetch_pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire = imem_rsp_valid && (inflight_q != '0);

    assign q_push_data = '{instr: imem_rsp_data, pc: rsp_pc_q};

    // Decode side is driven from registered queue state only.
    assign instr_valid = !q_empty;
    assign instr       = q_empty ? '0 : q_head.instr;
    assign instr_pc    = q_empty ? '0 : q_head.pc;

    // Next-state for PCs, credit and drop counters; redirect overrides everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);
        drop_cnt_d = drop_cnt_q;
        q_push     = 1'b0;
        q_flush    = 1'b0;

        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            rsp_pc_d   = align_pc(redirect_pc);
            q_flush    = 1'b1;
            // Everything still outstanding after this cycle's response belongs to the old path.
            drop_cnt_d = inflight_q - CW'(rsp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = next_pc(fetch_pc_q);
            end
            if (rsp_fire) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - 1'b1;
                end else begin
                    q_push   = 1'b1;
                    rsp_pc_d = next_pc(rsp_pc_q);
                end
            end
        end
    end

    // State registers; run_q holds off requests until the first clock after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            run_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            run_q      <= 1'b1;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (q_flush),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (instr_ready),
        .head      (q_head),
        .empty     (q_empty),
        .count     (q_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-order memory model with random latency and a
// program-order reference (expected request/delivery PC streams restarted on redirect).
module tb_fetch_stage;
    import rv_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            redirect_valid = 1'b0;
    logic [63:0]     redirect_pc = '0;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [63:0]     imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [31:0]     imem_rsp_data = '0;
    logic            instr_valid;
    logic            instr_ready = 1'b0;
    logic [31:0]     instr;
    logic [63:0]     instr_pc;

    always #5 clk = ~clk;

    fetch_stage #(
        .DEPTH    (DEPTH),
        .RESET_PC (64'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    mreq_t       memq[$];
    logic [63:0] got_pc[$];
    int          cycle;
    int          last_due;
    int unsigned lat_lo, lat_hi, req_pct, ins_pct;
    logic [63:0] exp_pc, exp_req;
    bit          pend_hold;
    logic [63:0] hold_addr;
    int          req_count;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          s_req_valid, s_req_fire, s_instr_valid;
    logic [63:0] s_req_addr;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    function automatic void clear_model();
        memq.delete();
        got_pc.delete();
        last_due  = 0;
        exp_pc    = 64'h0;
        exp_req   = 64'h0;
        pend_hold = 1'b0;
        req_count = 0;
    endfunction

    // Compare this cycle's handshakes against the reference streams and advance the model.
    function automatic void observe();
        int unsigned lat;
        int          due;
        s_req_valid   = imem_req_valid;
        s_instr_valid = instr_valid;
        s_req_addr    = imem_req_addr;
        s_req_fire    = imem_req_valid && imem_req_ready;
        if (redirect_valid) begin
            chk("redirect_no_req", imem_req_valid, 0);
        end else if (pend_hold) begin
            chk("req_hold_valid", imem_req_valid, 1);
            chk("req_hold_addr", imem_req_addr, hold_addr);
        end
        if (s_req_fire) begin
            chk("req_addr", imem_req_addr, exp_req);
            exp_req = exp_req + 64'd4;
            lat = $urandom_range(lat_hi, lat_lo);
            due = cycle + int'(lat);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            memq.push_back('{addr: imem_req_addr, due: due});
            req_count++;
        end
        pend_hold = imem_req_valid && !imem_req_ready;
        hold_addr = imem_req_addr;
        if (instr_valid && instr_ready) begin
            chk("instr_pc", instr_pc, exp_pc);
            chk("instr_word", instr, mem_word(exp_pc));
            got_pc.push_back(instr_pc);
            exp_pc = exp_pc + 64'd4;
        end
        if (imem_rsp_valid) void'(memq.pop_front());
        if (redirect_valid) begin
            exp_pc  = {redirect_pc[63:2], 2'b00};
            exp_req = {redirect_pc[63:2], 2'b00};
        end
    endfunction

    // mode: 0 none, 1 redirect now, 2 redirect when a response and a delivery coincide,
    // 3 occasional random redirect.
    task automatic step(input int mode, input logic [63:0] target, output bit redirected);
        bit rsp_due;
        @(negedge clk);
        rsp_due        = (memq.size() != 0) && (memq[0].due <= cycle);
        imem_req_ready = ($urandom_range(99) < req_pct);
        instr_ready    = ($urandom_range(99) < ins_pct);
        redirected     = (mode == 1) || (mode == 2 && rsp_due && instr_valid) ||
                         (mode == 3 && $urandom_range(99) < 3);
        if (mode == 2 && redirected) instr_ready = 1'b1;
        redirect_valid = redirected;
        redirect_pc    = (mode == 3) ? {32'h0, $urandom} : target;
        imem_rsp_valid = rsp_due;
        imem_rsp_data  = rsp_due ? mem_word(memq[0].addr) : $urandom;
        #1;
        observe();
        @(posedge clk);
        cycle++;
    endtask

    task automatic run(input int n, input int mode);
        bit r;
        for (int i = 0; i < n; i++) step(mode, 64'h0, r);
    endtask

    task automatic reset_dut(input int n);
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_instr_valid", instr_valid, 0);
            chk("rst_instr", instr, 0);
            chk("rst_instr_pc", instr_pc, 0);
            @(negedge clk);
        end
        rst = 1'b0;
        clear_model();
        @(posedge clk);
        cycle = 1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit r;
        bit found;
        int c;
        lat_lo = 1; lat_hi = 1; req_pct = 100; ins_pct = 100;
        clear_model();

        // Reset behaviour, then full-rate streaming with a 1-cycle memory.
        reset_dut(3);
        for (int i = 0; i < 24; i++) begin
            c = cycle;
            step(0, 64'h0, r);
            if (c == 1) begin
                chk("first_req_valid", s_req_valid, 1);
                chk("first_req_addr", s_req_addr, 64'h0);
            end
            chk("stream_instr_valid", s_instr_valid, (c >= 3));
        end

        // Decode stalled: credit limit stops requests at DEPTH, resume continues at 0x10.
        reset_dut(2);
        ins_pct = 0;
        run(12, 0);
        chk("credit_requests", req_count, DEPTH);
        chk("credit_stall", s_req_valid, 0);
        ins_pct = 100;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(0, 64'h0, r);
            if (s_req_fire) begin
                found = 1'b1;
                chk("resume_addr", s_req_addr, 64'h10);
            end
        end
        chk("resume_seen", found, 1);

        // Asynchronous reset pulse between edges with data buffered.
        ins_pct = 0;
        run(4, 0);
        chk("pulse_pre_valid", instr_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("pulse_instr_valid", instr_valid, 0);
        chk("pulse_req_valid", imem_req_valid, 0);
        chk("pulse_instr_pc", instr_pc, 0);
        #1 rst = 1'b0;
        clear_model();
        cycle = 0;
        ins_pct = 100;
        step(0, 64'h0, r);
        step(0, 64'h0, r);
        chk("pulse_restart_addr", s_req_addr, 64'h0);
        run(10, 0);

        // 3-cycle memory: redirect with two requests outstanding.
        reset_dut(2);
        lat_lo = 3; lat_hi = 3;
        run(2, 0);
        chk("outstanding_at_redirect", memq.size(), 2);
        step(1, 64'h100, r);
        got_pc.delete();
        step(0, 64'h0, r);
        chk("req_after_redirect", s_req_addr, 64'h100);
        run(14, 0);
        chk("deliv_after_redirect", got_pc.size() > 0, 1);
        if (got_pc.size() > 0) chk("first_after_redirect", got_pc[0], 64'h100);

        // Redirect coinciding with a response and a decode handshake.
        lat_lo = 1; lat_hi = 4; req_pct = 70; ins_pct = 60;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(2, 64'h200, r);
            found = r;
        end
        chk("coincide_found", found, 1);
        step(0, 64'h0, r);
        chk("flush_after_redirect", s_instr_valid, 0);
        run(40, 0);

        // PC wrap at the top of the address space; low redirect bits ignored.
        req_pct = 100; ins_pct = 100; lat_lo = 1; lat_hi = 2;
        step(1, 64'hFFFF_FFFF_FFFF_FFF9, r);
        got_pc.delete();
        run(20, 0);
        chk("wrap_count", got_pc.size() >= 3, 1);
        if (got_pc.size() >= 3) begin
            chk("wrap_pc0", got_pc[0], 64'hFFFF_FFFF_FFFF_FFF8);
            chk("wrap_pc1", got_pc[1], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("wrap_pc2", got_pc[2], 64'h0);
        end
        step(1, 64'h103, r);
        got_pc.delete();
        run(10, 0);
        chk("align_count", got_pc.size() > 0, 1);
        if (got_pc.size() > 0) chk("align_pc", got_pc[0], 64'h100);

        // Random soak with occasional redirects and varying back-pressure.
        for (int k = 0; k < 4; k++) begin
            req_pct = $urandom_range(100, 30);
            ins_pct = $urandom_range(100, 30);
            lat_lo  = 1;
            lat_hi  = $urandom_range(5, 1);
            run(150, 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
